// File: rtl/uart_tx_unit.sv
// Buffered 8N1 UART transmitter.
// Bytes are queued in a small circular FIFO and serialised LSB first on tx.
// A private 16x-oversampling baud tick generator paces each bit; it is held
// at zero while the FSM is idle, so every bit lasts exactly 16*BAUD_DVSR clk.
module uart_tx_unit #(
  parameter int DBIT      = 8,    // data bits per frame
  parameter int SB_TICK   = 16,   // oversampling ticks in the stop bit
  parameter int BAUD_DVSR = 163,  // clk cycles per oversampling tick
  parameter int FIFO_W    = 2     // FIFO address width, depth = 2**FIFO_W
) (
  input  logic            clk,
  input  logic            reset,    // asynchronous, active low
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  output logic            tx_full,
  output logic            tx_busy,
  output logic            tx
);

  localparam int DEPTH = 2 ** FIFO_W;
  localparam int B_W   = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
  localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [B_W-1:0] BAUD_LAST = B_W'(BAUD_DVSR - 1);
  localparam logic [S_W-1:0] OS_LAST   = S_W'(15);
  localparam logic [S_W-1:0] SB_LAST   = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] DBIT_LAST = N_W'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] w_ptr_q, w_ptr_d;
  logic [FIFO_W-1:0] r_ptr_q, r_ptr_d;
  logic [FIFO_W-1:0] w_succ, r_succ;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push, pop;

  // FSM state (declared here because the FIFO pop depends on it)
  state_e          state_q, state_d;
  logic [B_W-1:0]  baud_q, baud_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            tick;

  // A write while full is dropped even if the FSM pops in the same cycle.
  assign push = wr_uart & ~full_q;
  assign pop  = (state_q == IDLE) & ~empty_q;

  // Pointer advance and registered full/empty flag update.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    w_succ  = w_ptr_q + FIFO_W'(1);
    r_succ  = r_ptr_q + FIFO_W'(1);
    unique case ({push, pop})
      2'b10: begin
        w_ptr_d = w_succ;
        empty_d = 1'b0;
        full_d  = (w_succ == r_ptr_q);
      end
      2'b01: begin
        r_ptr_d = r_succ;
        full_d  = 1'b0;
        empty_d = (r_succ == w_ptr_q);
      end
      2'b11: begin
        // Occupancy unchanged: neither flag can flip.
        w_ptr_d = w_succ;
        r_ptr_d = r_succ;
      end
      default: ;
    endcase
  end

  // FIFO storage write port.
  // NOTE: the data array is deliberately left out of reset; the pointers and
  // flags define what is valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[w_ptr_q] <= w_data;
  end

  // FIFO pointer and flag registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Baud generator and transmit FSM
  // ---------------------------------------------------------------------------
  assign tick = (baud_q == BAUD_LAST);

  // Next-state, counter and line-level logic of the transmitter.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;

    // Baud counter is frozen at zero in IDLE so a new frame starts in phase.
    if (state_q == IDLE)  baud_d = '0;
    else if (tick)        baud_d = '0;
    else                  baud_d = baud_q + B_W'(1);

    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          shift_d = mem[r_ptr_q];
          s_d     = '0;
          n_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == DBIT_LAST) state_d = STOP;
            else                  n_d = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FSM, counters, shift register and registered line output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_full = full_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit (BAUD_DVSR=4, so one bit = 64 clk).
// A line receiver model decodes every frame on tx and pops the expected byte
// from a scoreboard queue filled when each accepted write is driven.
module tb_uart_tx_unit;

  localparam int BIT_CLK = 64;
  localparam int HALF    = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_uart = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       tx_full, tx_busy, tx;

  uart_tx_unit #(
    .DBIT(8), .SB_TICK(16), .BAUD_DVSR(4), .FIFO_W(2)
  ) dut (
    .clk(clk), .reset(reset), .wr_uart(wr_uart), .w_data(w_data),
    .tx_full(tx_full), .tx_busy(tx_busy), .tx(tx)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         rx_frames = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // wire order: line[9] = start bit first, line[0] = stop
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Line receiver model: detects the start edge, samples mid-bit, checks framing.
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  initial begin : rx_model
    forever begin
      @(negedge clk);
      if (!reset) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (tx === 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == HALF) begin
          if (tx !== 1'b0) begin
            check("rx_start", {31'd0, tx}, 32'd0);
            rx_busy = 1'b0;
          end
        end else if (rx_cnt > HALF && ((rx_cnt - HALF) % BIT_CLK) == 0) begin
          if ((rx_cnt - HALF) / BIT_CLK <= 8) begin
            rx_sh = {tx, rx_sh[7:1]};
          end else begin
            check("rx_stop", {31'd0, tx}, 32'd1);
            if (exp_q.size() == 0)
              fail_now("rx_unexpected", $sformatf("got frame %0h, required none", rx_sh));
            else
              check("rx_data", {24'd0, rx_sh}, {24'd0, exp_q.pop_front()});
            rx_frames++;
            rx_busy = 1'b0;
          end
        end
      end
    end
  end

  // Starting at the negedge where tx first reads low, sample all ten bits mid-bit.
  task automatic capture_frame(output logic [9:0] line);
    repeat (HALF) @(negedge clk);
    line[9] = tx;
    for (int k = 8; k >= 0; k--) begin
      repeat (BIT_CLK) @(negedge clk);
      line[k] = tx;
    end
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (tx_busy && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (tx_busy) fail_now(name, "tx_busy never dropped");
  endtask

  task automatic wait_frames(input int target, input string name);
    int c = 0;
    while (rx_frames < target && c < 6000) begin
      @(negedge clk);
      c++;
    end
    check(name, rx_frames, target);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       vecs[4];
    logic [9:0] line;
    int         idx;
    int         lows;
    int         busys;
    int         frames0;

    vecs[0] = '{8'h08, 10'b0_00010000_1};
    vecs[1] = '{8'h00, 10'b0_00000000_1};
    vecs[2] = '{8'hFF, 10'b0_11111111_1};
    vecs[3] = '{8'h55, 10'b0_10101010_1};

    // Reset held low for 5 cycles.
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_full", {31'd0, tx_full}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);

    // Single frames: latency, line pattern and busy duration.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      wr_uart = 1'b1;
      w_data  = vecs[i].data;
      exp_q.push_back(vecs[i].data);
      @(posedge clk);                 // write edge N
      @(negedge clk);
      wr_uart = 1'b0;
      check("lat_hold", {31'd0, tx}, 32'd1);
      @(negedge clk);                 // after edge N+1
      check("lat_fall", {31'd0, tx}, 32'd0);
      check("busy_on", {31'd0, tx_busy}, 32'd1);
      capture_frame(line);
      check("frame", {22'd0, line}, {22'd0, vecs[i].line});
      idx = 32 + 9 * BIT_CLK;
      while (tx_busy && idx < 2000) begin
        @(negedge clk);
        idx++;
      end
      check("busy_len", idx, 640);
    end
    wait_frames(4, "frames_single");

    // Back-to-back writes: two frames separated by exactly one idle clk.
    @(posedge clk); #1;
    wr_uart = 1'b1;
    w_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    w_data  = 8'h3C;
    exp_q.push_back(8'h3C);
    @(posedge clk);
    @(negedge clk);
    wr_uart = 1'b0;
    check("b2b_fall", {31'd0, tx}, 32'd0);
    capture_frame(line);
    check("b2b_frame0", {22'd0, line}, {22'd0, 10'b0_10100101_1});
    repeat (31) @(negedge clk);       // last stop-bit cycle
    check("b2b_stop_tx", {31'd0, tx}, 32'd1);
    check("b2b_stop_busy", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);                   // the single idle cycle
    check("b2b_idle_tx", {31'd0, tx}, 32'd1);
    check("b2b_idle_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    check("b2b_start", {31'd0, tx}, 32'd0);
    capture_frame(line);
    check("b2b_frame1", {22'd0, line}, {22'd0, 10'b0_00111100_1});
    wait_frames(6, "frames_b2b");
    wait_idle("b2b_idle_wait");

    // Six writes while idle: first popped at once, four fill the FIFO, sixth dropped.
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (j > 0) check("burst_full", {31'd0, tx_full}, {31'd0, (j == 5)});
      wr_uart = 1'b1;
      w_data  = 8'(8'h11 * (j + 1));
      if (j < 5) exp_q.push_back(8'(8'h11 * (j + 1)));
    end
    @(posedge clk); #1;               // edge N+5: sixth write dropped
    wr_uart = 1'b0;
    check("full_hold", {31'd0, tx_full}, 32'd1);
    repeat (637) @(negedge clk);      // negedge before the pop edge of byte 2
    check("pop_edge_full", {31'd0, tx_full}, 32'd1);
    wr_uart = 1'b1;
    w_data  = 8'h77;                  // coincides with the pop edge: dropped
    @(negedge clk);
    check("full_clear", {31'd0, tx_full}, 32'd0);
    w_data  = 8'h88;                  // first cycle with room: accepted
    exp_q.push_back(8'h88);
    @(negedge clk);
    wr_uart = 1'b0;
    check("refull", {31'd0, tx_full}, 32'd1);
    wait_frames(12, "frames_burst");
    repeat (200) @(negedge clk);
    check("burst_no_extra", rx_frames, 12);
    check("burst_busy", {31'd0, tx_busy}, 32'd0);
    check("burst_sb_empty", exp_q.size(), 0);

    // Reset in the middle of the 0xFF data bits with the FIFO full.
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      wr_uart = 1'b1;
      w_data  = (j == 0) ? 8'hFF : 8'(j);
      exp_q.push_back(w_data);
    end
    @(posedge clk); #1;
    wr_uart = 1'b0;
    repeat (300) @(negedge clk);
    #3;
    check("pre_rst_full", {31'd0, tx_full}, 32'd1);
    check("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("mid_rst_full", {31'd0, tx_full}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    frames0 = rx_frames;
    lows = 0;
    busys = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
    end
    check("post_rst_quiet", lows, 0);
    check("post_rst_busy", busys, 0);
    check("post_rst_frames", rx_frames, frames0);

    // A fresh write after reset is transmitted normally.
    @(posedge clk); #1;
    wr_uart = 1'b1;
    w_data  = 8'hC3;
    exp_q.push_back(8'hC3);
    @(posedge clk); #1;
    wr_uart = 1'b0;
    wait_frames(frames0 + 1, "frames_post_rst");
    wait_idle("final_idle");
    check("final_sb_empty", exp_q.size(), 0);
    check("final_frames", rx_frames, 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
